pxs_pattern_sequencer: RTL
==========================

PXS_PATTERN_SEQUENCER -- requirements
Module: pxs_pattern_sequencer

Interface
REQ-001 Parameter FRAMES_PER_PATTERN, default 60: frames each pattern is shown in AUTO mode; legal range 1..1023.
REQ-002 Parameter NUM_PATTERNS, default 4: number of patterns in the AUTO rotation; legal range 1..4.
REQ-003 px_clk  in  1  pixel clock; the only clock.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 VGA_SCA_Str_i  in  23  input stream; HS, VS, XC[9:0], YC[9:0] and Active fields per the Pxs.vh field macros.
REQ-006 cmd_valid  in  1  host command request.
REQ-007 cmd_pattern  in  2  requested pattern index.
REQ-008 cmd_hold  in  1  1 = freeze on cmd_pattern (HOLD); 0 = resume AUTO rotation starting at cmd_pattern.
REQ-009 cmd_ready  out  1  1 = no command pending; a command is accepted when cmd_valid and cmd_ready are both 1 in the same cycle.
REQ-010 VGA_SCA_Str_o  out  23  input stream delayed by exactly 1 cycle, bit-identical.
REQ-011 pattern_o  out  2  current pattern index, aligned with VGA_SCA_Str_o.
REQ-012 grid_log2_o  out  3  checkerboard cell size as log2: 6 - pattern_o (64, 32, 16, 8 px).
REQ-013 frame_start_o  out  1  one-cycle pulse aligned with the output word that carries the frame boundary.
REQ-014 mode_o  out  2  FSM state: 0 IDLE, 1 AUTO, 2 HOLD.

Function
REQ-015 Frame boundary: a cycle in which input VS = 1 and the registered previous input VS = 0 (rising edge of VS).
REQ-016 All outputs are registered; frame_start_o, pattern_o, grid_log2_o and mode_o update in the same cycle as the VGA_SCA_Str_o word that they describe.
REQ-017 IDLE -> AUTO on the first frame boundary after reset; pattern stays 0 and frame_cnt is loaded with 0.
REQ-018 AUTO: on each frame boundary, if frame_cnt = FRAMES_PER_PATTERN-1, frame_cnt becomes 0 and pattern advances by 1, wrapping from NUM_PATTERNS-1 to 0; otherwise frame_cnt increments.
REQ-019 HOLD: pattern is frozen and frame_cnt is held at 0.
REQ-020 Command acceptance: the accepted cmd_pattern/cmd_hold are latched into a pending slot and cmd_ready drops in the cycle after acceptance.
REQ-021 A pending command is applied only at the next frame boundary after acceptance; a command accepted in the same cycle as a frame boundary waits for the following boundary.
REQ-022 Applying a command: pattern = cmd_pattern, frame_cnt = 0, state = HOLD if cmd_hold is 1, else AUTO; cmd_ready returns to 1 in the same cycle.
REQ-023 A command applied while the FSM is in IDLE also performs the IDLE exit (REQ-017); the command's values take precedence.
REQ-024 In AUTO, a cmd_pattern >= NUM_PATTERNS is accepted but is clamped to NUM_PATTERNS-1 when applied; in HOLD any value 0..3 is legal.
REQ-025 Mid-frame mode and pattern changes are forbidden: pattern_o changes only in cycles in which frame_start_o = 1.
REQ-026 frame_cnt is 10 bits wide and is internal only.

Reset
REQ-027 While rst_n = 0, at each px_clk edge: VGA_SCA_Str_o = 0, pattern_o = 0, grid_log2_o = 6, frame_start_o = 0, mode_o = IDLE, cmd_ready = 1, frame_cnt = 0, pending slot empty, previous-VS register = 1 (so a frame already in sync does not trigger a boundary).
REQ-028 Reset asserted mid-frame or while a command is pending discards the pending command; the first boundary after rst_n deasserts follows REQ-017.

Verification
REQ-029 Reset, then 3 frames with FRAMES_PER_PATTERN=2, NUM_PATTERNS=4 -> frame 1 enters AUTO with pattern 0; frame 3 gives pattern 1, grid_log2_o = 5; each frame_start_o is a single cycle.
REQ-030 AUTO rotation over 8 frames with FRAMES_PER_PATTERN=1 -> pattern sequence 0,1,2,3,0,1,2,3; wrap confirmed; stream out equals stream in delayed 1 cycle.
REQ-031 Mid-frame command cmd_hold=1, cmd_pattern=2 -> cmd_ready = 0 the next cycle; pattern unchanged until the next boundary, then pattern 2, mode HOLD, grid_log2_o = 4, cmd_ready = 1; pattern stays 2 for 5 more frames.
REQ-032 Command accepted in the same cycle as a boundary -> not applied at that boundary, applied at the next one; a second cmd_valid while cmd_ready = 0 is ignored.
REQ-033 Command hold=0, pattern=3 with NUM_PATTERNS=2 -> pattern 1 (clamped) at the boundary, mode AUTO, rotation continues 0,1.
REQ-034 rst_n pulsed low mid-frame with a command pending -> all outputs at REQ-027 values, pending command lost; the next VS rising edge returns to AUTO with pattern 0.

Source files
------------

// File: rtl/pxs_pattern_sequencer.sv
// Checkerboard test-pattern sequencer for the pixel stream.
// Delays the stream by one cycle and attaches a pattern index, a grid size
// and a frame-start marker. Patterns rotate automatically every
// FRAMES_PER_PATTERN frames (AUTO), or are frozen by a host command (HOLD).
// Host commands take effect only on a frame boundary, so a frame is never
// drawn with two different patterns.
//
// Stream word layout: {HS, VS, XC[9:0], YC[9:0], Active}; only VS is
// interpreted here, every other field passes through untouched.

module pxs_pattern_sequencer #(
    parameter int FRAMES_PER_PATTERN = 60,  // 1..1023
    parameter int NUM_PATTERNS       = 4    // 1..4
) (
    input  logic        px_clk,
    input  logic        rst_n,
    input  logic [22:0] VGA_SCA_Str_i,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_pattern,
    input  logic        cmd_hold,
    output logic        cmd_ready,
    output logic [22:0] VGA_SCA_Str_o,
    output logic [1:0]  pattern_o,
    output logic [2:0]  grid_log2_o,
    output logic        frame_start_o,
    output logic [1:0]  mode_o
);

    localparam int VS_BIT = 21;

    localparam logic [1:0] LAST_PATTERN = 2'(NUM_PATTERNS - 1);
    localparam logic [9:0] LAST_FRAME   = 10'(FRAMES_PER_PATTERN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AUTO = 2'd1,
        HOLD = 2'd2
    } mode_e;

    mode_e       state_q, state_d;
    logic [1:0]  pattern_d;
    logic [2:0]  grid_log2_d;
    logic [9:0]  frame_cnt_q, frame_cnt_d;
    logic        cmd_ready_d;
    logic [1:0]  pend_pattern_q, pend_pattern_d;
    logic        pend_hold_q, pend_hold_d;
    logic        prev_vs_q;

    logic        boundary;
    logic        accept;
    logic        apply;

    // A frame starts on the rising edge of VS; prev_vs_q resets high so a
    // stream that is already inside vertical sync at reset release is not
    // mistaken for a new frame.
    assign boundary = VGA_SCA_Str_i[VS_BIT] & ~prev_vs_q;

    // cmd_ready low means the pending slot holds a command. Acceptance and
    // application are mutually exclusive: a command accepted on a boundary
    // cycle only becomes pending after it, so it waits for the next one.
    assign accept = cmd_valid & cmd_ready;
    assign apply  = boundary & ~cmd_ready;

    assign mode_o = state_q;

    // Next-state logic for the mode FSM, pattern, frame counter and command slot.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the branches below can leave one unassigned and infer a latch.
        state_d        = state_q;
        pattern_d      = pattern_o;
        frame_cnt_d    = frame_cnt_q;
        cmd_ready_d    = cmd_ready;
        pend_pattern_d = pend_pattern_q;
        pend_hold_d    = pend_hold_q;

        if (accept) begin
            cmd_ready_d    = 1'b0;
            pend_pattern_d = cmd_pattern;
            pend_hold_d    = cmd_hold;
        end

        if (boundary) begin
            if (apply) begin
                // A pending command overrides whatever the current mode would do,
                // including the IDLE exit.
                cmd_ready_d = 1'b1;
                frame_cnt_d = '0;
                if (pend_hold_q) begin
                    state_d   = HOLD;
                    pattern_d = pend_pattern_q;
                end else begin
                    state_d   = AUTO;
                    pattern_d = (pend_pattern_q > LAST_PATTERN) ? LAST_PATTERN : pend_pattern_q;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d     = AUTO;
                        pattern_d   = 2'd0;
                        frame_cnt_d = '0;
                    end
                    AUTO: begin
                        if (frame_cnt_q >= LAST_FRAME) begin
                            frame_cnt_d = '0;
                            pattern_d   = (pattern_o >= LAST_PATTERN) ? 2'd0 : pattern_o + 2'd1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 10'd1;
                        end
                    end
                    HOLD: begin
                        frame_cnt_d = '0;
                    end
                    default: begin
                        state_d     = IDLE;
                        pattern_d   = 2'd0;
                        frame_cnt_d = '0;
                    end
                endcase
            end
        end

        grid_log2_d = 3'd6 - {1'b0, pattern_d};
    end

    // State register: all outputs update together with the stream word they describe.
    always_ff @(posedge px_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q        <= IDLE;
            pattern_o      <= 2'd0;
            grid_log2_o    <= 3'd6;
            frame_cnt_q    <= '0;
            cmd_ready      <= 1'b1;
            pend_pattern_q <= 2'd0;
            pend_hold_q    <= 1'b0;
            prev_vs_q      <= 1'b1;
            VGA_SCA_Str_o  <= '0;
            frame_start_o  <= 1'b0;
        end else begin
            state_q        <= state_d;
            pattern_o      <= pattern_d;
            grid_log2_o    <= grid_log2_d;
            frame_cnt_q    <= frame_cnt_d;
            cmd_ready      <= cmd_ready_d;
            pend_pattern_q <= pend_pattern_d;
            pend_hold_q    <= pend_hold_d;
            prev_vs_q      <= VGA_SCA_Str_i[VS_BIT];
            VGA_SCA_Str_o  <= VGA_SCA_Str_i;
            frame_start_o  <= boundary;
        end
    end

endmodule
